// File: rtl/gift_cofb_ise_arb_if.sv
// Request/response/ALU signal bundle for the GIFT-COFB ISE arbiter.
// The arbiter uses the slave modport; requesters plus the ALU sit on the master side.
interface gift_cofb_ise_arb_if;
  logic        rq0_val;
  logic        rq0_rdy;
  logic [4:0]  rq0_fn;
  logic [6:0]  rq0_imm;
  logic [31:0] rq0_in1;
  logic [31:0] rq0_in2;
  logic        rs0_val;
  logic        rs0_rdy;
  logic [31:0] rs0_out;
  logic        rs0_ill;

  logic        rq1_val;
  logic        rq1_rdy;
  logic [4:0]  rq1_fn;
  logic [6:0]  rq1_imm;
  logic [31:0] rq1_in1;
  logic [31:0] rq1_in2;
  logic        rs1_val;
  logic        rs1_rdy;
  logic [31:0] rs1_out;
  logic        rs1_ill;

  logic [4:0]  alu_fn;
  logic [6:0]  alu_imm;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_val;
  logic        alu_oval;
  logic [31:0] alu_out;

  modport slave (
    input  rq0_val, rq0_fn, rq0_imm, rq0_in1, rq0_in2, rs0_rdy,
    input  rq1_val, rq1_fn, rq1_imm, rq1_in1, rq1_in2, rs1_rdy,
    input  alu_oval, alu_out,
    output rq0_rdy, rs0_val, rs0_out, rs0_ill,
    output rq1_rdy, rs1_val, rs1_out, rs1_ill,
    output alu_fn, alu_imm, alu_in1, alu_in2, alu_val
  );

  modport master (
    output rq0_val, rq0_fn, rq0_imm, rq0_in1, rq0_in2, rs0_rdy,
    output rq1_val, rq1_fn, rq1_imm, rq1_in1, rq1_in2, rs1_rdy,
    output alu_oval, alu_out,
    input  rq0_rdy, rs0_val, rs0_out, rs0_ill,
    input  rq1_rdy, rs1_val, rs1_out, rs1_ill,
    input  alu_fn, alu_imm, alu_in1, alu_in2, alu_val
  );
endinterface

// File: rtl/gift_cofb_ise_arb.sv
// Two-requester arbiter and issue sequencer sharing one GIFT-COFB ISE ALU:
// grant -> registered issue stage -> combinational ALU -> per-requester response buffer.
module gift_cofb_ise_arb #(
  parameter bit          PRIO0 = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic               ise_clk,
  input  logic               ise_rst,
  gift_cofb_ise_arb_if.slave ise_bus,
  output logic [CNT_W-1:0]   op_cnt,
  output logic [CNT_W-1:0]   ill_cnt
);

  logic [1:0]  rq_val;
  logic [1:0]  rs_rdy;
  logic [4:0]  rq_fn  [2];
  logic [6:0]  rq_imm [2];
  logic [31:0] rq_in1 [2];
  logic [31:0] rq_in2 [2];

  assign rq_val    = {ise_bus.rq1_val, ise_bus.rq0_val};
  assign rs_rdy    = {ise_bus.rs1_rdy, ise_bus.rs0_rdy};
  assign rq_fn[0]  = ise_bus.rq0_fn;
  assign rq_fn[1]  = ise_bus.rq1_fn;
  assign rq_imm[0] = ise_bus.rq0_imm;
  assign rq_imm[1] = ise_bus.rq1_imm;
  assign rq_in1[0] = ise_bus.rq0_in1;
  assign rq_in1[1] = ise_bus.rq1_in1;
  assign rq_in2[0] = ise_bus.rq0_in2;
  assign rq_in2[1] = ise_bus.rq1_in2;

  logic        s1_val_q, s1_val_d;
  logic        s1_id_q,  s1_id_d;
  logic [4:0]  s1_fn_q,  s1_fn_d;
  logic [6:0]  s1_imm_q, s1_imm_d;
  logic [31:0] s1_in1_q, s1_in1_d;
  logic [31:0] s1_in2_q, s1_in2_d;

  logic [1:0]  rs_val_q, rs_val_d;
  logic [1:0]  rs_ill_q, rs_ill_d;
  logic [31:0] rs_out_q [2];
  logic [31:0] rs_out_d [2];

  logic             last_q, last_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [1:0] elig;
  logic [1:0] req;
  logic [1:0] grant;

  // One op in flight per requester; a full response buffer being drained this cycle frees the slot.
  assign elig[0] = !(s1_val_q && !s1_id_q) && !(rs_val_q[0] && !rs_rdy[0]);
  assign elig[1] = !(s1_val_q &&  s1_id_q) && !(rs_val_q[1] && !rs_rdy[1]);
  assign req     = rq_val & elig;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (PRIO0 || last_q) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_comb begin
    s1_val_d = |grant;
    s1_id_d  = grant[1];
    s1_fn_d  = '0;
    s1_imm_d = '0;
    s1_in1_d = '0;
    s1_in2_d = '0;
    last_d   = last_q;
    if (|grant) begin
      s1_fn_d  = rq_fn[grant[1]];
      s1_imm_d = rq_imm[grant[1]];
      s1_in1_d = rq_in1[grant[1]];
      s1_in2_d = rq_in2[grant[1]];
      last_d   = grant[1];
    end
  end

  always_comb begin
    rs_val_d = rs_val_q;
    rs_ill_d = rs_ill_q;
    rs_out_d = rs_out_q;
    for (int unsigned x = 0; x < 2; x++) begin
      if (s1_val_q && (s1_id_q == 1'(x))) begin
        rs_val_d[x] = 1'b1;
        rs_out_d[x] = ise_bus.alu_oval ? ise_bus.alu_out : '0;
        rs_ill_d[x] = !ise_bus.alu_oval;
      end else if (rs_val_q[x] && rs_rdy[x]) begin
        rs_val_d[x] = 1'b0;
      end
    end
    op_cnt_d  = op_cnt_q  + CNT_W'(s1_val_q);
    ill_cnt_d = ill_cnt_q + CNT_W'(s1_val_q && !ise_bus.alu_oval);
  end

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      s1_val_q  <= 1'b0;
      s1_id_q   <= 1'b0;
      s1_fn_q   <= '0;
      s1_imm_q  <= '0;
      s1_in1_q  <= '0;
      s1_in2_q  <= '0;
      rs_val_q  <= '0;
      rs_ill_q  <= '0;
      rs_out_q  <= '{default: '0};
      last_q    <= 1'b1;
      op_cnt_q  <= '0;
      ill_cnt_q <= '0;
    end else begin
      s1_val_q  <= s1_val_d;
      s1_id_q   <= s1_id_d;
      s1_fn_q   <= s1_fn_d;
      s1_imm_q  <= s1_imm_d;
      s1_in1_q  <= s1_in1_d;
      s1_in2_q  <= s1_in2_d;
      rs_val_q  <= rs_val_d;
      rs_ill_q  <= rs_ill_d;
      rs_out_q  <= rs_out_d;
      last_q    <= last_d;
      op_cnt_q  <= op_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign ise_bus.rq0_rdy = grant[0];
  assign ise_bus.rq1_rdy = grant[1];
  assign ise_bus.rs0_val = rs_val_q[0];
  assign ise_bus.rs1_val = rs_val_q[1];
  assign ise_bus.rs0_out = rs_out_q[0];
  assign ise_bus.rs1_out = rs_out_q[1];
  assign ise_bus.rs0_ill = rs_ill_q[0];
  assign ise_bus.rs1_ill = rs_ill_q[1];

  // Issue fields are loaded as zero on idle cycles, so the ALU sees all-zero operands when alu_val is low.
  assign ise_bus.alu_val = s1_val_q;
  assign ise_bus.alu_fn  = s1_fn_q;
  assign ise_bus.alu_imm = s1_imm_q;
  assign ise_bus.alu_in1 = s1_in1_q;
  assign ise_bus.alu_in2 = s1_in2_q;

  assign op_cnt  = op_cnt_q;
  assign ill_cnt = ill_cnt_q;

endmodule

// File: tb/tb_gift_cofb_ise_arb.sv
// Bench for gift_cofb_ise_arb: a round-robin/16-bit instance and a fixed-priority/4-bit instance
// share random stimulus and are each compared against a transaction-level model with a stub ALU.
module tb_gift_cofb_ise_arb;

  logic clk;
  logic rst;

  gift_cofb_ise_arb_if if_rr ();
  gift_cofb_ise_arb_if if_fp ();

  logic [15:0] opc_rr, illc_rr;
  logic [3:0]  opc_fp, illc_fp;

  gift_cofb_ise_arb #(.PRIO0(1'b0), .CNT_W(16)) u_rr (
    .ise_clk (clk),
    .ise_rst (rst),
    .ise_bus (if_rr),
    .op_cnt  (opc_rr),
    .ill_cnt (illc_rr)
  );

  gift_cofb_ise_arb #(.PRIO0(1'b1), .CNT_W(4)) u_fp (
    .ise_clk (clk),
    .ise_rst (rst),
    .ise_bus (if_fp),
    .op_cnt  (opc_fp),
    .ill_cnt (illc_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: fn 3 is undecoded, everything else produces a mixing function of the operands.
  function automatic logic alu_ok(input logic [4:0] fn);
    return fn != 5'd3;
  endfunction

  function automatic logic [31:0] alu_res(input logic [4:0] fn, input logic [6:0] imm,
                                          input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + {20'b0, imm, fn};
  endfunction

  assign if_rr.alu_oval = alu_ok(if_rr.alu_fn);
  assign if_rr.alu_out  = alu_res(if_rr.alu_fn, if_rr.alu_imm, if_rr.alu_in1, if_rr.alu_in2);
  assign if_fp.alu_oval = alu_ok(if_fp.alu_fn);
  assign if_fp.alu_out  = alu_res(if_fp.alu_fn, if_fp.alu_imm, if_fp.alu_in1, if_fp.alu_in2);

  logic [1:0]  o_rq_rdy [2];
  logic [1:0]  o_rs_val [2];
  logic [1:0]  o_rs_ill [2];
  logic [31:0] o_rs_out [2][2];
  logic        o_alu_val [2];
  logic [31:0] o_alu_in1 [2];
  logic [31:0] o_opc [2];
  logic [31:0] o_illc [2];

  assign o_rq_rdy[0]    = {if_rr.rq1_rdy, if_rr.rq0_rdy};
  assign o_rq_rdy[1]    = {if_fp.rq1_rdy, if_fp.rq0_rdy};
  assign o_rs_val[0]    = {if_rr.rs1_val, if_rr.rs0_val};
  assign o_rs_val[1]    = {if_fp.rs1_val, if_fp.rs0_val};
  assign o_rs_ill[0]    = {if_rr.rs1_ill, if_rr.rs0_ill};
  assign o_rs_ill[1]    = {if_fp.rs1_ill, if_fp.rs0_ill};
  assign o_rs_out[0][0] = if_rr.rs0_out;
  assign o_rs_out[0][1] = if_rr.rs1_out;
  assign o_rs_out[1][0] = if_fp.rs0_out;
  assign o_rs_out[1][1] = if_fp.rs1_out;
  assign o_alu_val[0]   = if_rr.alu_val;
  assign o_alu_val[1]   = if_fp.alu_val;
  assign o_alu_in1[0]   = if_rr.alu_in1;
  assign o_alu_in1[1]   = if_fp.alu_in1;
  assign o_opc[0]       = {16'b0, opc_rr};
  assign o_opc[1]       = {28'b0, opc_fp};
  assign o_illc[0]      = {16'b0, illc_rr};
  assign o_illc[1]      = {28'b0, illc_fp};

  int unsigned n_chk;
  int unsigned n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Model: each requester owns at most one outstanding op, visible as a response from a known edge on.
  bit          m_pend   [2][2];
  int unsigned m_vis_e  [2][2];
  logic [31:0] m_out    [2][2];
  bit          m_ill    [2][2];
  bit          m_last   [2];
  bit          m_prio   [2];
  int unsigned m_ops    [2];
  int unsigned m_ills   [2];
  bit          m_iss    [2];
  bit          m_iss_ill[2];
  logic [31:0] m_iss_in1[2];
  logic [31:0] m_mask   [2];
  int unsigned ec;

  logic        s_v [2];
  logic        s_r [2];
  logic [4:0]  s_fn [2];
  logic [6:0]  s_imm [2];
  logic [31:0] s_in1 [2];
  logic [31:0] s_in2 [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        m_pend[d][x] = 1'b0;
        m_vis_e[d][x] = 0;
      end
      m_last[d] = 1'b1;
      m_ops[d] = 0;
      m_ills[d] = 0;
      m_iss[d] = 1'b0;
      m_iss_ill[d] = 1'b0;
      m_iss_in1[d] = '0;
    end
    ec = 0;
  endtask

  task automatic drive();
    if_rr.rq0_val = s_v[0];   if_fp.rq0_val = s_v[0];
    if_rr.rq1_val = s_v[1];   if_fp.rq1_val = s_v[1];
    if_rr.rs0_rdy = s_r[0];   if_fp.rs0_rdy = s_r[0];
    if_rr.rs1_rdy = s_r[1];   if_fp.rs1_rdy = s_r[1];
    if_rr.rq0_fn  = s_fn[0];  if_fp.rq0_fn  = s_fn[0];
    if_rr.rq1_fn  = s_fn[1];  if_fp.rq1_fn  = s_fn[1];
    if_rr.rq0_imm = s_imm[0]; if_fp.rq0_imm = s_imm[0];
    if_rr.rq1_imm = s_imm[1]; if_fp.rq1_imm = s_imm[1];
    if_rr.rq0_in1 = s_in1[0]; if_fp.rq0_in1 = s_in1[0];
    if_rr.rq1_in1 = s_in1[1]; if_fp.rq1_in1 = s_in1[1];
    if_rr.rq0_in2 = s_in2[0]; if_fp.rq0_in2 = s_in2[0];
    if_rr.rq1_in2 = s_in2[1]; if_fp.rq1_in2 = s_in2[1];
  endtask

  // Entered just after a rising edge; checks at the falling edge, then advances the model over the next edge.
  task automatic run_cycle(input bit v0, input bit v1, input bit r0, input bit r1);
    bit          vis  [2];
    bit          req  [2];
    logic [1:0]  g;
    s_v[0] = v0; s_v[1] = v1; s_r[0] = r0; s_r[1] = r1;
    for (int x = 0; x < 2; x++) begin
      s_fn[x]  = 5'($urandom_range(0, 5));
      s_imm[x] = 7'($urandom);
      s_in1[x] = $urandom;
      s_in2[x] = $urandom;
    end
    drive();
    #4;
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        vis[x] = m_pend[d][x] && (ec >= m_vis_e[d][x]);
        req[x] = s_v[x] && (!m_pend[d][x] || (vis[x] && s_r[x]));
      end
      g = 2'b00;
      if (req[0] && req[1]) g = (m_prio[d] || m_last[d]) ? 2'b01 : 2'b10;
      else if (req[0])      g = 2'b01;
      else if (req[1])      g = 2'b10;

      chk($sformatf("d%0d rq_rdy", d), 32'(o_rq_rdy[d]), 32'(g));
      for (int x = 0; x < 2; x++) begin
        chk($sformatf("d%0d rs%0d_val", d, x), 32'(o_rs_val[d][x]), 32'(vis[x]));
        if (vis[x]) begin
          chk($sformatf("d%0d rs%0d_out", d, x), o_rs_out[d][x], m_out[d][x]);
          chk($sformatf("d%0d rs%0d_ill", d, x), 32'(o_rs_ill[d][x]), 32'(m_ill[d][x]));
        end
      end
      chk($sformatf("d%0d alu_val", d), 32'(o_alu_val[d]), 32'(m_iss[d]));
      chk($sformatf("d%0d alu_in1", d), o_alu_in1[d], m_iss[d] ? m_iss_in1[d] : 32'h0);
      chk($sformatf("d%0d op_cnt", d), o_opc[d], m_ops[d] & m_mask[d]);
      chk($sformatf("d%0d ill_cnt", d), o_illc[d], m_ills[d] & m_mask[d]);

      m_ops[d]  += 32'(m_iss[d]);
      m_ills[d] += 32'(m_iss_ill[d]);
      m_iss[d] = 1'b0;
      m_iss_ill[d] = 1'b0;
      for (int x = 0; x < 2; x++) begin
        if (vis[x] && s_r[x]) m_pend[d][x] = 1'b0;
        if (g[x]) begin
          m_pend[d][x]  = 1'b1;
          m_vis_e[d][x] = ec + 2;
          m_ill[d][x]   = !alu_ok(s_fn[x]);
          m_out[d][x]   = alu_ok(s_fn[x]) ? alu_res(s_fn[x], s_imm[x], s_in1[x], s_in2[x]) : 32'h0;
          m_iss[d]      = 1'b1;
          m_iss_ill[d]  = !alu_ok(s_fn[x]);
          m_iss_in1[d]  = s_in1[x];
          m_last[d]     = x[0];
        end
      end
    end
    @(posedge clk);
    ec++;
    #1;
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d rs_val", tag, d), 32'(o_rs_val[d]), 32'h0);
      chk($sformatf("%s d%0d rs_ill", tag, d), 32'(o_rs_ill[d]), 32'h0);
      chk($sformatf("%s d%0d rs0_out", tag, d), o_rs_out[d][0], 32'h0);
      chk($sformatf("%s d%0d alu_val", tag, d), 32'(o_alu_val[d]), 32'h0);
      chk($sformatf("%s d%0d op_cnt", tag, d), o_opc[d], 32'h0);
      chk($sformatf("%s d%0d ill_cnt", tag, d), o_illc[d], 32'h0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_prio[0] = 1'b0;
    m_prio[1] = 1'b1;
    m_mask[0] = 32'h0000_FFFF;
    m_mask[1] = 32'h0000_000F;
    for (int x = 0; x < 2; x++) begin
      s_v[x] = 1'b0; s_r[x] = 1'b1; s_fn[x] = '0; s_imm[x] = '0; s_in1[x] = '0; s_in2[x] = '0;
    end
    drive();
    model_reset();
    rst = 1'b1;
    #2;
    check_cleared("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Both requesters hammering with ready responses: alternation in RR, outstanding limit in FP.
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Hold requester 1's response for several cycles, then release it while requesting again.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Single requester with ready tied high: one op every two cycles.
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 800; i++)
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);

    // Asynchronous reset while requester 0 occupies the issue stage.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pre-rst alu_val", 32'(o_alu_val[0]), 32'h1);
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    drive();
    #2;
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++)
      run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
